sdram_host_arbiter: RTL and testbench

- Shares the single host port of sdram_controller between two requesters: port 0 (SPI2 memory bridge) and port 1 (general fabric master).
- Arbitrates round-robin and issues one wr_enable/rd_enable pulse per transaction.
- Tracks read completion via rd_ready, with a timeout so a lost read cannot hang the bus.
- Sits between the requesters and sdram_controller in the clk domain.

---
 rtl/sdram_host_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_host_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the sdram_controller host port
// between the SPI2 bridge (port 0) and the fabric master (port 1).
module sdram_host_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int RD_TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] sd_wr_addr,
  output logic [DATA_W-1:0] sd_wr_data,
  output logic              sd_wr_enable,
  output logic [ADDR_W-1:0] sd_rd_addr,
  output logic              sd_rd_enable,
  input  logic [DATA_W-1:0] sd_rd_data,
  input  logic              sd_rd_ready,
  input  logic              sd_busy
);

  localparam int CW = $clog2(RD_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_RD,
    DONE
  } state_t;

  state_t          state;
  logic            last_grant;
  logic            gnt;
  logic            we_q;
  logic [CW-1:0]   cnt;

  logic              pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that did not win last time gets the bus.
  assign pick      = (req_i == 2'b11) ? ~last_grant : req_i[1];
  assign sel_addr  = pick ? addr1_i : addr0_i;
  assign sel_wdata = pick ? wdata1_i : wdata0_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      we_q         <= 1'b0;
      cnt          <= '0;
      ack_o        <= 2'b00;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      sd_wr_addr   <= '0;
      sd_wr_data   <= '0;
      sd_wr_enable <= 1'b0;
      sd_rd_addr   <= '0;
      sd_rd_enable <= 1'b0;
    end else begin
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      ack_o        <= 2'b00;
      err_o        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!sd_busy && |req_i) begin
            gnt        <= pick;
            last_grant <= pick;
            we_q       <= we_i[pick];
            state      <= CMD;
            // Command fields are latched straight into the controller regs.
            if (we_i[pick]) begin
              sd_wr_enable <= 1'b1;
              sd_wr_addr   <= sel_addr;
              sd_wr_data   <= sel_wdata;
            end else begin
              sd_rd_enable <= 1'b1;
              sd_rd_addr   <= sel_addr;
            end
          end
        end
        CMD: begin
          if (we_q) begin
            ack_o <= gnt ? 2'b10 : 2'b01;
            state <= DONE;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (sd_rd_ready) begin
            rdata_o <= sd_rd_data;
            ack_o   <= gnt ? 2'b10 : 2'b01;
            state   <= DONE;
          end else if (cnt == CNT_MAX) begin
            rdata_o <= ERR_DATA;
            err_o   <= 1'b1;
            ack_o   <= gnt ? 2'b10 : 2'b01;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter with hand-computed
// expectations; RD_TIMEOUT shortened to 16.
module tb_sdram_host_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic [15:0] wdata0_i;
  logic [15:0] wdata1_i;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [15:0] rdata_o;
  logic [31:0] sd_wr_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_enable;
  logic [31:0] sd_rd_addr;
  logic        sd_rd_enable;
  logic [15:0] sd_rd_data;
  logic        sd_rd_ready;
  logic        sd_busy;

  int vectors = 0;
  int miscompares = 0;

  sdram_host_arbiter #(
    .ADDR_W(32),
    .DATA_W(16),
    .RD_TIMEOUT(16),
    .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .we_i(we_i),
    .addr0_i(addr0_i),
    .addr1_i(addr1_i),
    .wdata0_i(wdata0_i),
    .wdata1_i(wdata1_i),
    .ack_o(ack_o),
    .err_o(err_o),
    .rdata_o(rdata_o),
    .sd_wr_addr(sd_wr_addr),
    .sd_wr_data(sd_wr_data),
    .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr),
    .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready),
    .sd_busy(sd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ack"}, 64'(ack_o), 64'h0);
    chk({tag, ".err"}, 64'(err_o), 64'h0);
    chk({tag, ".rdata"}, 64'(rdata_o), 64'h0);
    chk({tag, ".wen"}, 64'(sd_wr_enable), 64'h0);
    chk({tag, ".ren"}, 64'(sd_rd_enable), 64'h0);
    chk({tag, ".waddr"}, 64'(sd_wr_addr), 64'h0);
    chk({tag, ".wdata"}, 64'(sd_wr_data), 64'h0);
    chk({tag, ".raddr"}, 64'(sd_rd_addr), 64'h0);
  endtask

  int n_wen, n_ren, n_ack;
  int ack0, ack1, k;
  logic [31:0] order [4];

  initial begin
    rst_n = 1'b0;
    req_i = 2'b00;
    we_i = 2'b00;
    addr0_i = '0;
    addr1_i = '0;
    wdata0_i = '0;
    wdata1_i = '0;
    sd_rd_data = '0;
    sd_rd_ready = 1'b0;
    sd_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // port 0 write
    req_i = 2'b01; we_i = 2'b01; addr0_i = 0; wdata0_i = 16'h1234;
    tick();
    chk("wr.wen", 64'(sd_wr_enable), 64'h1);
    chk("wr.waddr", 64'(sd_wr_addr), 64'h0);
    chk("wr.wdata", 64'(sd_wr_data), 64'h1234);
    chk("wr.ack_early", 64'(ack_o), 64'h0);
    req_i = 2'b00;
    tick();
    chk("wr.ack", 64'(ack_o), 64'h1);
    chk("wr.err", 64'(err_o), 64'h0);
    chk("wr.wen_off", 64'(sd_wr_enable), 64'h0);
    tick();
    chk("wr.ack_off", 64'(ack_o), 64'h0);

    // port 1 read, ready 5 cycles after rd_enable
    req_i = 2'b10; we_i = 2'b00; addr1_i = 10;
    tick();
    chk("rd.ren", 64'(sd_rd_enable), 64'h1);
    chk("rd.raddr", 64'(sd_rd_addr), 64'd10);
    req_i = 2'b00;
    n_ren = 0; n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_ren += int'(sd_rd_enable);
      n_ack += int'(ack_o != 0);
    end
    chk("rd.ren_once", 64'(n_ren), 64'h0);
    chk("rd.no_ack", 64'(n_ack), 64'h0);
    tick();
    sd_rd_ready = 1'b1; sd_rd_data = 16'h7777;
    tick();
    sd_rd_ready = 1'b0; sd_rd_data = 16'h0;
    chk("rd.ack", 64'(ack_o), 64'h2);
    chk("rd.rdata", 64'(rdata_o), 64'h7777);
    chk("rd.err", 64'(err_o), 64'h0);
    tick();

    // stray rd_ready while idle is ignored
    sd_rd_ready = 1'b1; sd_rd_data = 16'h1111;
    tick();
    sd_rd_ready = 1'b0;
    tick();
    chk("stray.rdata", 64'(rdata_o), 64'h7777);
    chk("stray.ack", 64'(ack_o), 64'h0);

    // both ports write continuously: 0,1,0,1
    req_i = 2'b11; we_i = 2'b11;
    addr0_i = 1; addr1_i = 2; wdata0_i = 16'hAAAA; wdata1_i = 16'hBBBB;
    ack0 = 0; ack1 = 0; k = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (sd_wr_enable && k < 4) begin
        order[k] = sd_wr_addr;
        k++;
      end
      ack0 += int'(ack_o[0]);
      ack1 += int'(ack_o[1]);
    end
    req_i = 2'b00;
    chk("rr.count", 64'(k), 64'd4);
    chk("rr.o0", 64'(order[0]), 64'd1);
    chk("rr.o1", 64'(order[1]), 64'd2);
    chk("rr.o2", 64'(order[2]), 64'd1);
    chk("rr.o3", 64'(order[3]), 64'd2);
    chk("rr.ack0", 64'(ack0), 64'd2);
    chk("rr.ack1", 64'(ack1), 64'd2);
    tick();

    // busy holds off the grant
    sd_busy = 1'b1;
    req_i = 2'b01; we_i = 2'b01; addr0_i = 5; wdata0_i = 16'h5555;
    n_wen = 0; n_ack = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_wen += int'(sd_wr_enable | sd_rd_enable);
      n_ack += int'(ack_o != 0);
    end
    chk("busy.en", 64'(n_wen), 64'h0);
    chk("busy.ack", 64'(n_ack), 64'h0);
    sd_busy = 1'b0;
    tick();
    chk("busy.wen", 64'(sd_wr_enable), 64'h1);
    chk("busy.waddr", 64'(sd_wr_addr), 64'd5);
    req_i = 2'b00;
    tick();
    chk("busy.ack_done", 64'(ack_o), 64'h1);
    tick();

    // read timeout
    req_i = 2'b10; we_i = 2'b00; addr1_i = 20;
    tick();
    chk("to.ren", 64'(sd_rd_enable), 64'h1);
    req_i = 2'b00;
    n_ack = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_ack += int'(ack_o != 0);
    end
    chk("to.no_ack", 64'(n_ack), 64'h0);
    tick();
    chk("to.ack", 64'(ack_o), 64'h2);
    chk("to.err", 64'(err_o), 64'h1);
    chk("to.rdata", 64'(rdata_o), 64'hDEAD);
    tick();
    chk("to.err_off", 64'(err_o), 64'h0);

    // next request served normally, rdata unchanged by write
    req_i = 2'b01; we_i = 2'b01; addr0_i = 7; wdata0_i = 16'h0707;
    tick();
    chk("nx.wen", 64'(sd_wr_enable), 64'h1);
    chk("nx.wdata", 64'(sd_wr_data), 64'h0707);
    req_i = 2'b00;
    tick();
    chk("nx.ack", 64'(ack_o), 64'h1);
    chk("nx.err", 64'(err_o), 64'h0);
    chk("nx.rdata", 64'(rdata_o), 64'hDEAD);
    tick();

    // reset during WAIT_RD
    req_i = 2'b01; we_i = 2'b00; addr0_i = 3;
    tick();
    chk("mr.ren", 64'(sd_rd_enable), 64'h1);
    req_i = 2'b00;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mr");
    n_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_ack += int'(ack_o != 0);
    end
    chk("mr.no_ack", 64'(n_ack), 64'h0);
    rst_n = 1'b1;
    tick();
    req_i = 2'b11; we_i = 2'b11; addr0_i = 1; addr1_i = 2;
    tick();
    chk("mr.tie_wen", 64'(sd_wr_enable), 64'h1);
    chk("mr.tie_addr", 64'(sd_wr_addr), 64'd1);
    tick();
    req_i = 2'b00;
    chk("mr.tie_ack", 64'(ack_o), 64'h1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
